branch_resolve: RTL and testbench

- Consumes the equality flag from the 32-bit equality comparator, plus the signed and unsigned less-than flags, for each conditional branch in the RV32I pipeline.
- Evaluates the branch condition from funct3, compares the outcome with the front-end prediction, and on a mispredict issues a registered redirect PC and a multi-cycle flush.
- Sits between the EX-stage comparators and the fetch/hazard logic.
- Keeps saturating branch and mispredict counters for performance monitoring.

---
 rtl/branch_resolve.sv | 137 +++++++++++++
 tb/tb_branch_resolve.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - RV32I conditional branch resolution with redirect, flush and perf counters
module branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_funct3,
  input  logic             i_eq,
  input  logic             i_lt,
  input  logic             i_ltu,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_target,
  input  logic             i_pred_taken,
  output logic             o_resolve_valid,
  output logic             o_taken,
  output logic             o_illegal,
  output logic             o_redirect_valid,
  output logic [31:0]      o_redirect_pc,
  output logic             o_flush,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispredict_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Loaded on a mispredict; FLUSH ends on the cycle the counter reads zero.
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] flush_cnt, flush_cnt_next;

  logic accept;
  logic legal;
  logic cond;
  logic mispredict;

  // Decode the branch condition from funct3 and the comparator flags.
  always_comb begin
    legal = 1'b1;
    cond  = 1'b0;
    case (i_funct3)
      3'b000:  cond = i_eq;
      3'b001:  cond = ~i_eq;
      3'b100:  cond = i_lt;
      3'b101:  cond = ~i_lt;
      3'b110:  cond = i_ltu;
      3'b111:  cond = ~i_ltu;
      default: legal = 1'b0;
    endcase
  end

  assign accept     = i_valid && o_ready;
  assign mispredict = accept && legal && (cond != i_pred_taken);

  // FSM state and flush counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      flush_cnt <= 4'd0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // Next-state logic; ready and flush are decoded straight from the state.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    o_ready        = 1'b0;
    o_flush        = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (mispredict) begin
          state_next     = FLUSH;
          flush_cnt_next = FLUSH_LAST;
        end
      end
      FLUSH: begin
        o_flush = 1'b1;
        if (flush_cnt == 4'd0) begin
          state_next = IDLE;
        end else begin
          flush_cnt_next = flush_cnt - 4'd1;
        end
      end
      default: begin
        state_next     = IDLE;
        flush_cnt_next = 4'd0;
      end
    endcase
  end

  // Registered resolution results; pulses clear unless a new descriptor is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_resolve_valid  <= 1'b0;
      o_taken          <= 1'b0;
      o_illegal        <= 1'b0;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= 32'd0;
    end else begin
      o_resolve_valid  <= accept;
      o_illegal        <= accept && !legal;
      o_redirect_valid <= mispredict;
      if (accept) begin
        o_taken <= legal && cond;
      end
      if (mispredict) begin
        o_redirect_pc <= cond ? i_target : (i_pc + 32'd4);
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_branch_cnt     <= '0;
      o_mispredict_cnt <= '0;
    end else begin
      if (accept && legal && (o_branch_cnt != {CNT_W{1'b1}})) begin
        o_branch_cnt <= o_branch_cnt + CNT_W'(1);
      end
      if (mispredict && (o_mispredict_cnt != {CNT_W{1'b1}})) begin
        o_mispredict_cnt <= o_mispredict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - self-checking bench for branch_resolve against a behavioural model
module tb_branch_resolve;

  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 4;
  localparam int CMAX         = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             valid;
  logic             ready;
  logic [2:0]       funct3;
  logic             eq, lt, ltu;
  logic [31:0]      pc, target;
  logic             pred_taken;
  logic             resolve_valid, taken, illegal, redirect_valid, flush;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] branch_cnt, mispredict_cnt;

  branch_resolve #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_valid          (valid),
    .o_ready          (ready),
    .i_funct3         (funct3),
    .i_eq             (eq),
    .i_lt             (lt),
    .i_ltu            (ltu),
    .i_pc             (pc),
    .i_target         (target),
    .i_pred_taken     (pred_taken),
    .o_resolve_valid  (resolve_valid),
    .o_taken          (taken),
    .o_illegal        (illegal),
    .o_redirect_valid (redirect_valid),
    .o_redirect_pc    (redirect_pc),
    .o_flush          (flush),
    .o_branch_cnt     (branch_cnt),
    .o_mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Reference model state.
  int          flush_left;
  int          exp_bcnt, exp_mcnt;
  logic        exp_rv, exp_tk, exp_ill, exp_rdv;
  logic [31:0] exp_rpc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    flush_left = 0;
    exp_bcnt   = 0;
    exp_mcnt   = 0;
    exp_rv     = 1'b0;
    exp_tk     = 1'b0;
    exp_ill    = 1'b0;
    exp_rdv    = 1'b0;
    exp_rpc    = 32'd0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".resolve_valid"},  32'(resolve_valid),  32'(exp_rv));
    chk({ctx, ".taken"},          32'(taken),          32'(exp_tk));
    chk({ctx, ".illegal"},        32'(illegal),        32'(exp_ill));
    chk({ctx, ".redirect_valid"}, 32'(redirect_valid), 32'(exp_rdv));
    chk({ctx, ".redirect_pc"},    redirect_pc,         exp_rpc);
    chk({ctx, ".flush"},          32'(flush),          32'(flush_left > 0));
    chk({ctx, ".ready"},          32'(ready),          32'(flush_left == 0));
    chk({ctx, ".branch_cnt"},     32'(branch_cnt),     32'(exp_bcnt));
    chk({ctx, ".mispredict_cnt"}, 32'(mispredict_cnt), 32'(exp_mcnt));
  endtask

  // Drive one descriptor for one cycle, predict its effect, then check after the edge.
  task automatic step(input string ctx, input logic v, input logic [2:0] f3,
                      input logic e, input logic l, input logic lu,
                      input logic [31:0] p, input logic [31:0] t, input logic pr);
    logic acc, lg, c;
    valid = v; funct3 = f3; eq = e; lt = l; ltu = lu;
    pc = p; target = t; pred_taken = pr;
    acc = v && (flush_left == 0);
    exp_rv = 1'b0; exp_ill = 1'b0; exp_rdv = 1'b0;
    if (acc) begin
      lg = 1'b1;
      c  = 1'b0;
      case (f3)
        3'd0: c = e;
        3'd1: c = !e;
        3'd4: c = l;
        3'd5: c = !l;
        3'd6: c = lu;
        3'd7: c = !lu;
        default: lg = 1'b0;
      endcase
      exp_rv = 1'b1;
      if (!lg) begin
        exp_ill = 1'b1;
        exp_tk  = 1'b0;
      end else begin
        exp_tk = c;
        if (exp_bcnt < CMAX) exp_bcnt++;
        if (c != pr) begin
          exp_rdv = 1'b1;
          exp_rpc = c ? t : p + 32'd4;
          if (exp_mcnt < CMAX) exp_mcnt++;
          flush_left = FLUSH_CYCLES;
        end
      end
    end else if (flush_left > 0) begin
      flush_left--;
    end
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input string ctx);
    step(ctx, 1'b0, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
         $urandom, $urandom, 1'($urandom));
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; valid = 1'b0; funct3 = 3'd0; eq = 1'b0; lt = 1'b0; ltu = 1'b0;
    pc = 32'd0; target = 32'd0; pred_taken = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    step("beq", 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_0100, 1'b1);
    chk("beq.taken_const", 32'(taken), 32'd1);
    chk("beq.bcnt_const", 32'(branch_cnt), 32'd1);

    step("bne", 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0300, 1'b1);
    chk("bne.redirect_pc_const", redirect_pc, 32'h0000_0204);
    idle("bne_flush1");
    chk("bne.flush_const", 32'(flush), 32'd1);
    idle("bne_flush2");
    chk("bne.ready_const", 32'(ready), 32'd1);

    step("bltu", 1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h0000_0080, 1'b0);
    chk("bltu.redirect_pc_const", redirect_pc, 32'h0000_0080);
    for (int i = 0; i < 3; i++)
      step("bltu_hold", 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0000_0084, 32'h0000_0090, 1'b1);
    chk("bltu_hold.accepted_const", 32'(resolve_valid), 32'd1);

    step("bge_ok", 1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_1000, 1'b1);
    step("bge_wrap", 1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_1000, 1'b1);
    chk("bge_wrap.redirect_pc_const", redirect_pc, 32'h0000_0000);
    idle("bge_flush1");
    idle("bge_flush2");

    step("illegal", 1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0600, 1'b1);
    chk("illegal.flag_const", 32'(illegal), 32'd1);
    idle("illegal_after");

    step("pre_rst", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0000_0700, 32'h0000_0800, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("post_rst");

    for (int i = 0; i < 16; i++) begin
      step("sat_mp", 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 32'h1000 + 32'(i * 4), 32'h2000, 1'b0);
      idle("sat_f1");
      idle("sat_f2");
    end
    chk("sat.mispredict_cnt_const", 32'(mispredict_cnt), 32'd15);

    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom,
           $urandom, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
